// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave front-end
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - loads one RAM byte and drives it on MISO, MSB first
module spi_tx_serializer
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso,
    output logic              done
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              miso_q, miso_d;

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        miso_d   = miso_q;
        if (clear) begin
            active_d = 1'b0;
            cnt_d    = 3'd0;
            miso_d   = 1'b0;
        end else if (load) begin
            // Bit 7 goes straight onto the pin; the rest wait in the shifter.
            miso_d   = load_data[DATA_W-1];
            shreg_d  = {load_data[DATA_W-2:0], 1'b0};
            cnt_d    = 3'd7;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q != 3'd0) begin
                miso_d  = shreg_q[DATA_W-1];
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q - 3'd1;
            end else begin
                miso_d   = 1'b0;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            cnt_q    <= 3'd0;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            miso_q   <= miso_d;
        end
    end

    // High while the final bit (bit 0) is on the pin.
    assign done = active_q && (cnt_q == 3'd0);
    assign miso = miso_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave framing FSM to RAM command port; SPI_CMD_CHECK_EN drops mismatched read frames
module spi_slave
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    state_t             state_q, state_d;
    logic [FRAME_W-2:0] sh_q, sh_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               tx_armed_q, tx_armed_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_prev_q, tx_prev_d;
    logic               ser_load, ser_clear, ser_done;
    logic               drop;

    always_comb begin
        state_d        = state_q;
        sh_d           = sh_q;
        bit_cnt_d      = bit_cnt_q;
        frame_done_d   = frame_done_q;
        tx_armed_d     = tx_armed_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        tx_prev_d      = tx_valid;
        ser_load       = 1'b0;
        ser_clear      = 1'b0;
`ifdef SPI_CMD_CHECK_EN
        drop = ((state_q == READ_ADD)  && (sh_q[FRAME_W-3] != CMD_RD_ADDR[0])) ||
               ((state_q == READ_DATA) && (sh_q[FRAME_W-3] != CMD_RD_DATA[0]));
`else
        drop = 1'b0;
`endif
        if ((state_q != IDLE) && SS_n) begin
            // Host abort: partial frame is thrown away, flag left as is.
            state_d      = IDLE;
            frame_done_d = 1'b0;
            tx_armed_d   = 1'b0;
            ser_clear    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!SS_n) begin
                        state_d      = CHK_CMD;
                        frame_done_d = 1'b0;
                        tx_armed_d   = 1'b0;
                    end
                end
                CHK_CMD: begin
                    sh_d      = {{(FRAME_W-2){1'b0}}, MOSI};
                    bit_cnt_d = 4'd0;
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                default: begin
                    if (!frame_done_q) begin
                        sh_d = {sh_q[FRAME_W-3:0], MOSI};
                        if (bit_cnt_q == 4'd8) begin
                            frame_done_d = 1'b1;
                            if (!drop) begin
                                rx_data_d  = {sh_q, MOSI};
                                rx_valid_d = 1'b1;
                                if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
                                if (state_q == READ_DATA) tx_armed_d     = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (state_q == READ_DATA) begin
                        if (tx_armed_q && tx_valid && !tx_prev_q) begin
                            ser_load   = 1'b1;
                            tx_armed_d = 1'b0;
                        end
                        if (ser_done) rd_addr_seen_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sh_q           <= '0;
            bit_cnt_q      <= 4'd0;
            frame_done_q   <= 1'b0;
            tx_armed_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_prev_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_q           <= sh_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_done_q   <= frame_done_d;
            tx_armed_q     <= tx_armed_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            tx_prev_q      <= tx_prev_d;
        end
    end

    spi_tx_serializer u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .clear     (ser_clear),
        .load_data (tx_data),
        .miso      (MISO),
        .done      (ser_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pulses;
    int         pulse_edge;
    logic [9:0] cap;
    logic       miso_log [0:31];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic log_cycle(input int e);
        if (rx_valid) begin
            pulses++;
            pulse_edge = e;
            cap = rx_data;
        end
        miso_log[e] = MISO;
    endtask

    // Edge e: e=0 SS_n seen low, e=1..10 carry frame bits 9..0.
    task automatic run_frame(input logic [9:0] frame, input int ncyc, input logic [7:0] txd,
                             input int tx_edge, input bit release_ss);
        pulses = 0;
        pulse_edge = -1;
        cap = '0;
        for (int i = 0; i < 32; i++) miso_log[i] = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            SS_n = 1'b0;
            MOSI = (e >= 1 && e <= 10) ? frame[10-e] : 1'b0;
            tx_valid = (tx_edge >= 0) && (e >= tx_edge);
            tx_data = txd;
            tick;
            log_cycle(e);
        end
        if (release_ss) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            tx_valid = 1'b0;
            tick;
            log_cycle(ncyc);
        end
    endtask

    function automatic logic miso_any(input int lo, input int hi);
        logic r = 1'b0;
        for (int i = lo; i <= hi; i++) r |= miso_log[i];
        return r;
    endfunction

    function automatic logic [7:0] miso_byte(input int start);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[6:0], miso_log[start+i]};
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (3) tick;
        expect_eq("reset_miso", MISO, 0);
        expect_eq("reset_rx_valid", rx_valid, 0);
        expect_eq("reset_rx_data", rx_data, 0);
        expect_eq("reset_flag", dut.rd_addr_seen_q, 0);
        rst_n = 1'b1;
        tick;

        run_frame(10'h05A, 11, 8'h00, -1, 1'b1);
        expect_eq("wa_pulses", pulses, 1);
        expect_eq("wa_pulse_edge", pulse_edge, 10);
        expect_eq("wa_rx_data", cap, 10'h05A);
        expect_eq("wa_miso_quiet", miso_any(0, 11), 0);

        run_frame(10'h1C3, 11, 8'h00, -1, 1'b1);
        expect_eq("wd_pulses", pulses, 1);
        expect_eq("wd_rx_data", cap, 10'h1C3);
        expect_eq("wd_flag", dut.rd_addr_seen_q, 0);

        run_frame(10'h25A, 11, 8'h00, -1, 1'b1);
        expect_eq("ra_rx_data", cap, 10'h25A);
        expect_eq("ra_flag_set", dut.rd_addr_seen_q, 1);

        run_frame(10'h300, 21, 8'hC3, 12, 1'b1);
        expect_eq("rd_pulses", pulses, 1);
        expect_eq("rd_pulse_edge", pulse_edge, 10);
        expect_eq("rd_rx_data", cap, 10'h300);
        expect_eq("rd_miso_pre", miso_any(0, 11), 0);
        expect_eq("rd_miso_byte", miso_byte(12), 8'hC3);
        expect_eq("rd_miso_post", miso_any(20, 21), 0);
        expect_eq("rd_flag_clear", dut.rd_addr_seen_q, 0);

        run_frame(10'h0FF, 7, 8'h00, -1, 1'b1);
        expect_eq("abort_pulses", pulses, 0);
        run_frame(10'h011, 11, 8'h00, -1, 1'b1);
        expect_eq("post_abort_pulses", pulses, 1);
        expect_eq("post_abort_rx_data", cap, 10'h011);

        run_frame(10'h300, 11, 8'h00, -1, 1'b1);
`ifdef SPI_CMD_CHECK_EN
        expect_eq("chk_drop_pulses", pulses, 0);
        expect_eq("chk_drop_flag", dut.rd_addr_seen_q, 0);
        run_frame(10'h25A, 11, 8'h00, -1, 1'b1);
`else
        expect_eq("nochk_pulses", pulses, 1);
        expect_eq("nochk_rx_data", cap, 10'h300);
`endif
        expect_eq("pre_reset_flag", dut.rd_addr_seen_q, 1);

        run_frame(10'h300, 16, 8'hA5, 12, 1'b0);
        expect_eq("rst_partial_miso", {miso_log[12], miso_log[13], miso_log[14], miso_log[15]}, 4'hA);
        rst_n = 1'b0;
        tick;
        expect_eq("rst_mid_miso", MISO, 0);
        expect_eq("rst_mid_rx_valid", rx_valid, 0);
        expect_eq("rst_mid_flag", dut.rd_addr_seen_q, 0);
        rst_n = 1'b1;
        SS_n = 1'b1;
        tx_valid = 1'b0;
        tick;

        run_frame(10'h222, 21, 8'hFF, 12, 1'b1);
        expect_eq("after_rst_rx_data", cap, 10'h222);
        expect_eq("after_rst_pulses", pulses, 1);
        expect_eq("after_rst_no_shift", miso_any(0, 21), 0);
        expect_eq("after_rst_flag", dut.rd_addr_seen_q, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
